setting_reg_bank_atomic: RTL

- Settings-bus consumer that sits directly downstream of the settings bus master (stb/addr/data write transactions).
- Holds NREGS shadow registers written individually over the bus.
- Copies all shadow registers to the outputs at once when the commit address is written, so multi-word configurations change on a single edge.
- A commit_hold input defers commits, e.g. until a DSP block is between packets.

---
 rtl/setting_reg_bank_atomic.sv | 79 +++++++
 1 files changed

// File: rtl/setting_reg_bank_atomic.sv
// Settings-bus shadow register bank: individual shadow writes, atomic copy to
// the outputs on a commit write, with commits deferrable by commit_hold.
module setting_reg_bank_atomic #(
    parameter int                AWIDTH    = 8,
    parameter int                DWIDTH    = 32,
    parameter int                BASE      = 0,
    parameter int                NREGS     = 4,
    parameter logic [DWIDTH-1:0] RESET_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    set_stb,
    input  logic [AWIDTH-1:0]       set_addr,
    input  logic [DWIDTH-1:0]       set_data,
    input  logic                    commit_hold,
    output logic [NREGS*DWIDTH-1:0] out_data,
    output logic                    out_changed,
    output logic [NREGS-1:0]        dirty,
    output logic                    commit_pending,
    output logic [15:0]             commit_count
);

    localparam logic [AWIDTH-1:0] COMMIT_ADDR = AWIDTH'(BASE + NREGS);

    logic [NREGS*DWIDTH-1:0] shadow_q;
    logic [NREGS-1:0]        wr_mask;
    logic                    commit_req;
    logic                    apply;

    always_comb begin
        wr_mask = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (set_stb && (set_addr == AWIDTH'(BASE + i))) begin
                wr_mask[i] = 1'b1;
            end
        end
    end

    assign commit_req = set_stb && (set_addr == COMMIT_ADDR);
    // A fresh request and a deferred one coincide into a single apply.
    assign apply      = !commit_hold && (commit_req || commit_pending);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= {NREGS{RESET_VAL}};
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_mask[i]) begin
                    shadow_q[i*DWIDTH +: DWIDTH] <= set_data;
                end
            end
        end
    end

    // Snapshot uses the pre-write shadow; a same-edge write stays dirty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data       <= {NREGS{RESET_VAL}};
            out_changed    <= 1'b0;
            dirty          <= '0;
            commit_pending <= 1'b0;
            commit_count   <= '0;
        end else begin
            out_changed <= apply;
            if (apply) begin
                out_data       <= shadow_q;
                dirty          <= wr_mask;
                commit_pending <= 1'b0;
                commit_count   <= commit_count + 16'd1;
            end else begin
                dirty <= dirty | wr_mask;
                if (commit_req) begin
                    commit_pending <= 1'b1;
                end
            end
        end
    end

endmodule
